// File: rtl/ysyx_23060332_mc_ctrl_if.sv
// rtl/ysyx_23060332_mc_ctrl_if.sv - fetch and load/store handshake bundle for the multi-cycle sequencer
interface ysyx_23060332_mc_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_req_addr;
  logic              ifu_resp_valid;
  logic [INST_W-1:0] ifu_resp_inst;
  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic              lsu_resp_valid;

  modport master (
    output ifu_req_valid, ifu_req_addr, lsu_req_valid,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_inst, lsu_req_ready, lsu_resp_valid
  );

  modport slave (
    input  ifu_req_valid, ifu_req_addr, lsu_req_valid,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_inst, lsu_req_ready, lsu_resp_valid
  );
endinterface

// File: rtl/ysyx_23060332_mc_ctrl.sv
// rtl/ysyx_23060332_mc_ctrl.sv - multi-cycle core sequencer with per-wait watchdog
// Optional perf counters: YSYX_23060332_PERF_CNT_EN
module ysyx_23060332_mc_ctrl #(
  parameter int               ADDR_W      = 32,
  parameter int               INST_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h8000_0000,
  parameter int               TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  ysyx_23060332_mc_ctrl_if.master mem,
  output logic [INST_W-1:0]   inst,
  output logic [ADDR_W-1:0]   pc,
  input  logic                dec_mem,
  input  logic                dec_ebreak,
  input  logic                dec_reg_wen,
  input  logic                jump_en,
  input  logic [ADDR_W-1:0]   jump_addr,
  output logic                reg_wen,
  output logic                halted,
  output logic                fault
`ifdef YSYX_23060332_PERF_CNT_EN
  ,
  output logic [63:0]         perf_cycle,
  output logic [63:0]         perf_instret
`endif
);

  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT
  } state_t;

  state_t          state;
  logic [WD_W-1:0] wd;
  logic            ifu_valid_q;
  logic            lsu_valid_q;

  logic misalign;
  logic wd_limit;
  logic wb_wen;

  assign misalign = jump_en && (jump_addr[1:0] != 2'b00);
  assign wd_limit = (wd == WD_LIMIT);
  // The write strobe is computed on entry to WB so reg_wen comes straight from a flop.
  assign wb_wen   = dec_reg_wen && !misalign;

  assign mem.ifu_req_valid = ifu_valid_q;
  assign mem.ifu_req_addr  = pc;
  assign mem.lsu_req_valid = lsu_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inst        <= INST_W'(32'h0000_0013);
      halted      <= 1'b0;
      fault       <= 1'b0;
      wd          <= '0;
      ifu_valid_q <= 1'b0;
      lsu_valid_q <= 1'b0;
      reg_wen     <= 1'b0;
`ifdef YSYX_23060332_PERF_CNT_EN
      perf_cycle   <= 64'd0;
      perf_instret <= 64'd0;
`endif
    end else begin
      reg_wen <= 1'b0;
`ifdef YSYX_23060332_PERF_CNT_EN
      if (!halted) perf_cycle <= perf_cycle + 64'd1;
`endif
      case (state)
        IDLE: begin
          state       <= FETCH;
          ifu_valid_q <= 1'b1;
          wd          <= '0;
        end
        FETCH: begin
          if (ifu_valid_q && mem.ifu_req_ready) begin
            state       <= FETCH_WAIT;
            ifu_valid_q <= 1'b0;
            wd          <= '0;
          end else if (wd_limit) begin
            state       <= HALT;
            halted      <= 1'b1;
            fault       <= 1'b1;
            ifu_valid_q <= 1'b0;
            wd          <= '0;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        FETCH_WAIT: begin
          if (mem.ifu_resp_valid) begin
            inst  <= mem.ifu_resp_inst;
            state <= EXEC;
            wd    <= '0;
          end else if (wd_limit) begin
            state  <= HALT;
            halted <= 1'b1;
            fault  <= 1'b1;
            wd     <= '0;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        EXEC: begin
          if (dec_ebreak) begin
            state  <= HALT;
            halted <= 1'b1;
            fault  <= 1'b0;
          end else if (dec_mem) begin
            state       <= MEM_REQ;
            lsu_valid_q <= 1'b1;
          end else begin
            state   <= WB;
            reg_wen <= wb_wen;
          end
          wd <= '0;
        end
        MEM_REQ: begin
          if (lsu_valid_q && mem.lsu_req_ready) begin
            state       <= MEM_WAIT;
            lsu_valid_q <= 1'b0;
            wd          <= '0;
          end else if (wd_limit) begin
            state       <= HALT;
            halted      <= 1'b1;
            fault       <= 1'b1;
            lsu_valid_q <= 1'b0;
            wd          <= '0;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem.lsu_resp_valid) begin
            state   <= WB;
            reg_wen <= wb_wen;
            wd      <= '0;
          end else if (wd_limit) begin
            state  <= HALT;
            halted <= 1'b1;
            fault  <= 1'b1;
            wd     <= '0;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        WB: begin
          // A misaligned target stops the core with the jump's own pc preserved.
          if (misalign) begin
            state  <= HALT;
            halted <= 1'b1;
            fault  <= 1'b1;
          end else begin
            pc          <= jump_en ? jump_addr : pc + ADDR_W'(4);
            state       <= FETCH;
            ifu_valid_q <= 1'b1;
`ifdef YSYX_23060332_PERF_CNT_EN
            perf_instret <= perf_instret + 64'd1;
`endif
          end
          wd <= '0;
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
